baud_pulse_gen: RTL and testbench
=================================

# baud_pulse_gen

Programmable bit-rate pulse generator for the RS-232 serial transmitter and receiver paths. It divides `clk` by a run-time divisor and produces three single-cycle strobes: a bit-boundary tick, a mid-bit sampling tick, and a frame-complete tick. The divisor can be reloaded without stopping the line, and the phase can be re-aligned on a detected start-bit edge. The UART RX/TX state machines use its strobes as their only timing reference.

## Interface
- `CNT_W`, 13: width of the bit-period counter and divisor.
- `DEFAULT_DIV`, 11: divisor after reset, in clk cycles per bit; must be ≥ 2 and < 2^CNT_W.
- `FRAME_BITS`, 10: bits per frame (start + data + stop); must be ≥ 1.
- `FRAC_W`, 4: fractional divisor width; only used with `BAUD_PULSE_FRAC_EN`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  count enable; low freezes all state except divisor loading.
- `restart`  in  1  phase re-align: clears the bit counter and frame index.
- `div_load`  in  1  one-cycle request to load `div_in` and `frac_in`.
- `div_in`  in  CNT_W  new integer divisor.
- `frac_in`  in  FRAC_W  new fractional divisor, in units of 1/2^FRAC_W cycle.
- `bit_tick`  out  1  last cycle of each bit period.
- `half_tick`  out  1  mid-bit sample strobe.
- `frame_done`  out  1  coincides with `bit_tick` of the last bit of a frame.
- `bit_idx`  out  ceil(log2(FRAME_BITS+1))  index of the current bit within the frame.
- `div_err`  out  1  one-cycle pulse when a load is rejected.
- `div_cur`  out  CNT_W  divisor currently in effect.

## Operation
- `count` runs 0 … P-1, where P is the current period (`div_cur`, or `div_cur`+1 for a stretched period).
- Strobe decodes:
  - `bit_tick` = `enable` & !`rst` & (`count` == P-1).
  - `half_tick` = `enable` & !`rst` & (`count` == (`div_cur`>>1)-1).
  - For `div_cur` = 2: `half_tick` fires at count 0, `bit_tick` at count 1.
- On `bit_tick`:
  - `count` goes to 0.
  - `bit_idx` increments, wrapping from FRAME_BITS-1 to 0.
  - `frame_done` = `bit_tick` & (`bit_idx` == FRAME_BITS-1).
- Divisor load:
  - `div_load` with `div_in` < 2: rejected. `div_err` pulses on the next cycle; nothing else changes.
  - Valid load while `enable` is low: applied to `div_cur` on the next cycle.
  - Valid load while `enable` is high: captured into a pending register and applied on the cycle after the next `bit_tick`, so no bit period is ever shortened.
  - A second valid load before a pending one is applied overwrites it (last wins).
- `restart` (only when `enable` is high):
  - next cycle: `count` = 0, `bit_idx` = 0, any pending divisor applied immediately.
  - `bit_tick`, `half_tick` and `frame_done` are suppressed in the restart cycle.
- Priority: `rst` > `restart` > `bit_tick` > plain increment. `div_load` is independent of `restart`; when both arrive in the same cycle, the new divisor takes effect at the restart.
- Reset values: `count` 0, `bit_idx` 0, `div_cur` = DEFAULT_DIV, pending cleared, fractional accumulator 0.
  - All strobes and `div_err` are 0 while `rst` is high and in the cycle it deasserts.
  - `rst` mid-period discards the partial period and any pending load.

## Timing
- The strobes are combinational from registered state, valid in the same cycle as the count match, and last exactly one cycle.
- With `enable` held high and no loads, `bit_tick` period = `div_cur` cycles; the first `bit_tick` after reset or restart is at relative cycle `div_cur`-1.
- `half_tick` leads `bit_tick` by `div_cur` - (`div_cur`>>1) cycles.
- Dropping `enable` mid-period holds `count`; raising it resumes from the held value with no lost or extra cycles.
- `count` arithmetic is CNT_W bits unsigned; P-1 never underflows because `div_cur` ≥ 2.

## Configuration
- `BAUD_PULSE_FRAC_EN` defined:
  - A FRAC_W-bit accumulator adds `frac_cur` on every `bit_tick`.
  - On carry-out, the following bit period is `div_cur`+1 cycles.
  - `frac_in` is loaded together with `div_in` under the same pending and rejection rules.
  - The average period is `div_cur` + `frac_cur`/2^FRAC_W.
  - `restart` clears the accumulator.
- Undefined:
  - The accumulator and `frac_cur` registers are not built; `frac_in` is present but ignored.
  - Every period is exactly `div_cur` cycles.

## Test plan
- Reset, `enable`=1, default parameters -> `bit_tick` at cycles 10, 21, 32; `half_tick` at cycles 4, 15, 26; `frame_done` with the 10th `bit_tick` (cycle 109); `bit_idx` wraps 9 -> 0.
- Load `div_in`=4 at cycle 3 of a period -> that period still ends at count 10; following periods are 4 cycles; `div_cur` changes the cycle after the boundary.
- `div_load` with `div_in`=1, and with 0 -> `div_err` pulses once each; `div_cur` stays 11; tick cadence unchanged.
- `restart` at count 7, `bit_idx` 3 -> no ticks in that cycle; next cycle `count`=0, `bit_idx`=0; next `bit_tick` 11 cycles after restart.
- `enable` low for 5 cycles at count 6 -> `bit_tick` delayed by exactly 5 cycles; no strobes while low.
- `BAUD_PULSE_FRAC_EN`, FRAC_W=4, `div_in`=10, `frac_in`=8 -> periods alternate 10, 11; 16 consecutive periods total 168 cycles.

Source files
------------

// File: rtl/baud_pulse_gen.sv
// baud_pulse_gen: programmable bit-rate divider producing bit, mid-bit and frame-complete strobes
// Ports: clk, rst (sync, active-high); enable (low freezes counting, loads still accepted);
//   restart (re-align phase, only while enabled); div_load/div_in/frac_in (divisor load request);
//   bit_tick/half_tick/frame_done (single-cycle strobes); bit_idx (bit position within frame);
//   div_err (pulse for a rejected load); div_cur (divisor in effect).
// Optional: define BAUD_PULSE_FRAC_EN to build the fractional divisor; otherwise frac_in is ignored.
module baud_pulse_gen #(
  parameter int CNT_W = 13,
  parameter int DEFAULT_DIV = 11,
  parameter int FRAME_BITS = 10,
  parameter int FRAC_W = 4,
  localparam int IDX_W = $clog2(FRAME_BITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             restart,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_in,
  input  logic [FRAC_W-1:0] frac_in,
  output logic             bit_tick,
  output logic             half_tick,
  output logic             frame_done,
  output logic [IDX_W-1:0] bit_idx,
  output logic             div_err,
  output logic [CNT_W-1:0] div_cur
);
  logic [CNT_W-1:0] r_count, r_div, r_pend_div, w_last, w_half;
  logic [IDX_W-1:0] r_idx;
  logic r_pend, r_err, w_valid, w_run, w_bound, w_str;
  assign w_valid = div_load & (div_in > CNT_W'(1));
  assign w_run = enable & ~rst & ~restart;
`ifdef BAUD_PULSE_FRAC_EN
  logic [FRAC_W-1:0] r_frac, r_pend_frac, r_acc;
  logic r_str;
  assign w_str = r_str;
`else
  logic w_unused;
  assign w_unused = ^frac_in;
  assign w_str = 1'b0;
`endif
  // A stretched period (accumulator carry) adds one cycle before the bit boundary.
  assign w_last = r_div - CNT_W'(1) + {{(CNT_W-1){1'b0}}, w_str};
  assign w_half = (r_div >> 1) - CNT_W'(1);
  assign bit_tick = w_run & (r_count == w_last);
  assign half_tick = w_run & (r_count == w_half);
  assign frame_done = bit_tick & (r_idx == IDX_W'(FRAME_BITS - 1));
  // Boundaries where a new divisor may take effect without shortening a period.
  assign w_bound = enable & (restart | bit_tick);
  assign bit_idx = r_idx;
  assign div_err = r_err;
  assign div_cur = r_div;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_idx <= '0;
      r_div <= CNT_W'(DEFAULT_DIV);
      r_pend <= 1'b0;
      r_pend_div <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= div_load & ~w_valid;
      if (enable & restart) begin
        r_count <= '0;
        r_idx <= '0;
      end else if (bit_tick) begin
        r_count <= '0;
        r_idx <= frame_done ? '0 : r_idx + 1'b1;
      end else if (enable) begin
        r_count <= r_count + 1'b1;
      end
      // A load arriving on a boundary wins over an older pending value.
      if (w_bound) begin
        r_div <= w_valid ? div_in : r_pend ? r_pend_div : r_div;
        r_pend <= 1'b0;
      end else if (w_valid & ~enable) begin
        r_div <= div_in;
        r_pend <= 1'b0;
      end else if (w_valid) begin
        r_pend <= 1'b1;
        r_pend_div <= div_in;
      end
    end
  end
`ifdef BAUD_PULSE_FRAC_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frac <= '0;
      r_pend_frac <= '0;
      r_acc <= '0;
      r_str <= 1'b0;
    end else begin
      if (enable & restart) {r_str, r_acc} <= '0;
      else if (bit_tick) {r_str, r_acc} <= {1'b0, r_acc} + {1'b0, r_frac};
      if (w_bound) r_frac <= w_valid ? frac_in : r_pend ? r_pend_frac : r_frac;
      else if (w_valid & ~enable) r_frac <= frac_in;
      else if (w_valid) r_pend_frac <= frac_in;
    end
  end
`endif
endmodule

// File: tb/tb_baud_pulse_gen.sv
// tb_baud_pulse_gen: randomized and directed checks of baud_pulse_gen against a behavioural model
module tb_baud_pulse_gen;
  localparam int CW = 13;
  localparam int FB = 10;
  localparam int FW = 4;
  localparam int IW = $clog2(FB + 1);
`ifdef BAUD_PULSE_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, enable, restart, div_load;
  logic [CW-1:0] div_in;
  logic [FW-1:0] frac_in;
  logic bit_tick, half_tick, frame_done, div_err;
  logic [IW-1:0] bit_idx;
  logic [CW-1:0] div_cur;
  baud_pulse_gen dut (
    .clk(clk), .rst(rst), .enable(enable), .restart(restart),
    .div_load(div_load), .div_in(div_in), .frac_in(frac_in),
    .bit_tick(bit_tick), .half_tick(half_tick), .frame_done(frame_done),
    .bit_idx(bit_idx), .div_err(div_err), .div_cur(div_cur)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0, t = 0, t0 = 0, n_err = 0;
  int q_bt[$], q_ht[$], q_fd[$];
  int m_el = 0, m_idx = 0, m_div = 0, m_pdiv = 0, m_frac = 0, m_pfrac = 0, m_acc = 0, m_extra = 0;
  bit m_pend = 0, m_err = 0, m_ok = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, t);
    end
  endtask
  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction
  task automatic clr();
    q_bt.delete();
    q_ht.delete();
    q_fd.delete();
  endtask
  // One clock cycle: drive, compare against the model at negedge, advance the model.
  task automatic cyc(input bit r, input bit e, input bit s, input bit l, input int d, input int f);
    int per, sum;
    bit bt, ht, fd, valid;
    rst = r; enable = e; restart = s; div_load = l; div_in = CW'(d); frac_in = FW'(f);
    @(negedge clk);
    per = m_div + m_extra;
    bt = e && !r && !s && m_el == per - 1;
    ht = e && !r && !s && m_el == m_div / 2 - 1;
    fd = bt && m_idx == FB - 1;
    chk("bit_tick", int'(bit_tick), int'(bt));
    chk("half_tick", int'(half_tick), int'(ht));
    chk("frame_done", int'(frame_done), int'(fd));
    if (m_ok) begin
      chk("bit_idx", int'(bit_idx), m_idx);
      chk("div_err", int'(div_err), int'(m_err));
      chk("div_cur", int'(div_cur), m_div);
    end
    if (bit_tick) q_bt.push_back(t - t0);
    if (half_tick) q_ht.push_back(t - t0);
    if (frame_done) q_fd.push_back(t - t0);
    if (div_err) n_err++;
    if (r) begin
      m_ok = 1; m_el = 0; m_idx = 0; m_div = 11; m_pend = 0; m_err = 0;
      m_frac = 0; m_pfrac = 0; m_acc = 0; m_extra = 0;
    end else begin
      valid = l && d >= 2;
      m_err = l && !valid;
      if (e && s) begin
        m_el = 0; m_idx = 0; m_acc = 0; m_extra = 0;
      end else if (bt) begin
        m_el = 0;
        m_idx = (m_idx + 1) % FB;
        sum = m_acc + m_frac;
        m_extra = sum >= (1 << FW) ? 1 : 0;
        m_acc = sum % (1 << FW);
      end else if (e) begin
        m_el++;
      end
      if (e && (s || bt)) begin
        if (valid) begin m_div = d; m_frac = FRAC_ON ? f : 0; end
        else if (m_pend) begin m_div = m_pdiv; m_frac = m_pfrac; end
        m_pend = 0;
      end else if (valid && !e) begin
        m_div = d; m_frac = FRAC_ON ? f : 0; m_pend = 0;
      end else if (valid) begin
        m_pend = 1; m_pdiv = d; m_pfrac = FRAC_ON ? f : 0;
      end
    end
    @(posedge clk);
    #1;
    t++;
  endtask
  initial begin
    bit found;
    repeat (3) cyc(1, 1, 0, 0, 0, 0);
    t0 = t;
    clr();
    repeat (110) cyc(0, 1, 0, 0, 0, 0);
    chk("bt0", qget(q_bt, 0), 10);
    chk("bt1", qget(q_bt, 1), 21);
    chk("bt2", qget(q_bt, 2), 32);
    chk("ht0", qget(q_ht, 0), 4);
    chk("ht1", qget(q_ht, 1), 15);
    chk("ht2", qget(q_ht, 2), 26);
    chk("fd0", qget(q_fd, 0), 109);
    chk("idx_wrap", int'(bit_idx), 0);
    clr();
    repeat (3) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 4, 0);
    repeat (22) cyc(0, 1, 0, 0, 0, 0);
    chk("load_bt0", qget(q_bt, 0), 120);
    chk("load_bt1", qget(q_bt, 1), 124);
    chk("load_bt2", qget(q_bt, 2), 128);
    cyc(0, 1, 0, 1, 11, 0);
    repeat (15) cyc(0, 1, 0, 0, 0, 0);
    n_err = 0;
    cyc(0, 1, 0, 1, 1, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0);
    repeat (3) cyc(0, 1, 0, 0, 0, 0);
    chk("err_pulses", n_err, 2);
    chk("err_div_cur", int'(div_cur), 11);
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (m_idx == 3 && m_el == 7) found = 1;
      else cyc(0, 1, 0, 0, 0, 0);
    end
    chk("restart_point", int'(found), 1);
    clr();
    t0 = t;
    cyc(0, 1, 1, 0, 0, 0);
    chk("restart_idx", int'(bit_idx), 0);
    repeat (12) cyc(0, 1, 0, 0, 0, 0);
    chk("restart_bt", qget(q_bt, 0), 11);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_el == 6) found = 1;
      else cyc(0, 1, 0, 0, 0, 0);
    end
    chk("hold_point", int'(found), 1);
    clr();
    t0 = t - 6;
    repeat (5) cyc(0, 0, 0, 0, 0, 0);
    repeat (12) cyc(0, 1, 0, 0, 0, 0);
    chk("hold_bt", qget(q_bt, 0), 15);
    if (FRAC_ON) begin
      cyc(0, 0, 0, 1, 10, 8);
      clr();
      t0 = t;
      cyc(0, 1, 1, 0, 0, 0);
      repeat (185) cyc(0, 1, 0, 0, 0, 0);
      chk("frac_bt0", qget(q_bt, 0), 10);
      chk("frac_bt1", qget(q_bt, 1), 20);
      chk("frac_bt2", qget(q_bt, 2), 31);
      chk("frac_16", qget(q_bt, 16) - qget(q_bt, 0), 168);
    end
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
          $urandom_range(0, 19) == 0, int'($urandom_range(0, 14)), int'($urandom_range(0, 15)));
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
